counter_prog: RTL and testbench
===============================

// Module: counter_prog
// PURPOSE
//  Parametrised successor of the free-running counter. Adds configurable width,
//  up/down counting, synchronous load, enable with a programmable prescaler,
//  wrap or saturate at the range limits, and compare-match signalling.
//  Serves as the general timebase/event counter for the example RTL.
// PARAMETERS
//  WIDTH      128  counter width in bits (>=2)
//  PRE_W      8    prescaler width in bits (>=1)
//  SATURATE   0    0: wrap at limits; 1: hold at limits
// PORTS
//  clk_i       in   1      clock; all state updates on rising edge
//  rst_i       in   1      synchronous reset, active-high
//  en_i        in   1      count enable; the prescaler advances only when high
//  dir_i       in   1      0: count up; 1: count down (sampled on each step)
//  load_i      in   1      synchronous load of load_val_i
//  load_val_i  in   WIDTH  value loaded into count_o
//  prescale_i  in   PRE_W  one step every prescale_i+1 enabled cycles
//  cmp_val_i   in   WIDTH  compare value for match_o
//  count_o     out  WIDTH  current count
//  tick_o      out  1      1-cycle pulse: a step occurred on the previous edge
//  ovf_o       out  1      1-cycle pulse: a step hit a limit (wrap or saturate)
//  match_o     out  1      1-cycle pulse: count_o became == cmp_val_i
// BEHAVIOUR
//  - Reset: count_o=0, prescaler=0, tick_o=ovf_o=match_o=0.
//  - All outputs are registered. Their values reflect the edge just taken.
//  - Priority per edge: rst_i > load_i > step.
//  - Prescaler pre (PRE_W bits):
//    - If en_i=0, pre holds.
//    - If en_i=1 and pre >= prescale_i, then pre<=0 and step=1.
//    - Otherwise pre<=pre+1 and step=0.
//    - Using >= means a prescale_i reduced mid-count steps on the next enabled
//      cycle rather than waiting 2^PRE_W cycles.
//    - With prescale_i=0, a step occurs every enabled cycle.
//  - load_i=1:
//    - count_o<=load_val_i and pre<=0.
//    - A step pending on the same edge is discarded.
//    - tick_o=0 and ovf_o=0.
//  - Step up (dir_i=0):
//    - count_o<=count_o+1, modulo 2^WIDTH.
//    - At all-ones: SATURATE=0 wraps to 0; SATURATE=1 holds all-ones.
//    - ovf_o=1 in both cases.
//  - Step down (dir_i=1):
//    - count_o<=count_o-1.
//    - At 0: SATURATE=0 wraps to all-ones; SATURATE=1 holds 0.
//    - ovf_o=1 in both cases.
//  - tick_o<=step.
//    - A saturated step still pulses tick_o, even though count_o is unchanged.
//  - match_o<=(step|load_i) & (next count_o == cmp_val_i).
//    - Evaluated on the value just written.
//    - No repeat pulse while count_o rests on cmp_val_i without a new step or load.
//  - Changing dir_i or SATURATE behaviour never corrupts the prescaler phase.
//  - Reset asserted mid-operation wins over load and step on that edge.
//    - The next step then needs prescale_i+1 enabled cycles after reset deasserts.
// TESTING
//  1. Reset, en_i=1, prescale_i=0, dir_i=0 -> count_o 0,1,2,3 on successive
//     edges, tick_o high every cycle, ovf_o=0.
//  2. prescale_i=2, en_i=1 for 9 cycles -> count_o reaches 3, tick_o pulses on
//     cycles 3,6,9. Drop en_i for 4 cycles mid-sequence -> pre and count hold.
//  3. WIDTH=8, SATURATE=0: load 8'hFE, step up twice -> FF then 00, ovf_o
//     pulse on the 00 edge. Repeat with dir_i=1 from 01 -> 00 then FF,
//     ovf_o pulse on the FF edge.
//  4. WIDTH=8, SATURATE=1: from FF step up 3x -> stays FF, ovf_o and tick_o
//     pulse each step. From 00 step down -> stays 00, ovf_o=1.
//  5. cmp_val_i=5, count up from 0 -> match_o single pulse on the edge where
//     count_o becomes 5. load 5 with en_i=0 -> match_o pulse. Hold with
//     en_i=0 -> no further pulse.
//  6. load_i and a step on the same edge -> count_o=load_val_i, tick_o=0.
//     rst_i with load_i=1 -> count_o=0, all pulses 0.

Source files
------------

// File: rtl/counter_prog.sv
// Programmable up/down counter with prescaled enable, wrap/saturate limits
// and registered tick, overflow and compare-match pulses.
module counter_prog #(
  parameter int WIDTH    = 128,
  parameter int PRE_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             ovf_o,
  output logic             match_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;
  logic             step;
  logic             at_limit;

  // ">=" lets a prescale value lowered mid-count take effect immediately.
  assign step     = en_i && (pre_q >= prescale_i);
  assign at_limit = dir_i ? (count_q == '0) : (count_q == '1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    count_d = count_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    ovf_d   = 1'b0;
    match_d = 1'b0;

    if (load_i) begin
      count_d = load_val_i;
      pre_d   = '0;
      match_d = (load_val_i == cmp_val_i);
    end else begin
      if (en_i) begin
        pre_d = step ? '0 : pre_q + 1'b1;
      end
      if (step) begin
        tick_d = 1'b1;
        ovf_d  = at_limit;
        if (at_limit && SATURATE) begin
          count_d = count_q;
        end else if (dir_i) begin
          count_d = count_q - 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        match_d = (count_d == cmp_val_i);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign ovf_o   = ovf_q;
  assign match_o = match_q;

endmodule

// File: tb/tb_counter_prog.sv
// Bench for counter_prog: a wrapping and a saturating instance share stimulus
// and are compared every edge against an integer-arithmetic reference model.
module tb_counter_prog;

  localparam int W  = 8;
  localparam int PW = 4;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst, en, dir, load;
  logic [W-1:0]  load_val, cmp_val;
  logic [PW-1:0] prescale;

  logic [W-1:0] cnt_w, cnt_s;
  logic         tick_w, ovf_w, match_w;
  logic         tick_s, ovf_s, match_s;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 wraps, index 1 saturates.
  int m_pre;
  int m_cnt   [2];
  bit m_tick;
  bit m_ovf   [2];
  bit m_match [2];

  always #5 clk = ~clk;

  counter_prog #(.WIDTH(W), .PRE_W(PW), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
    .load_val_i(load_val), .prescale_i(prescale), .cmp_val_i(cmp_val),
    .count_o(cnt_w), .tick_o(tick_w), .ovf_o(ovf_w), .match_o(match_w)
  );

  counter_prog #(.WIDTH(W), .PRE_W(PW), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
    .load_val_i(load_val), .prescale_i(prescale), .cmp_val_i(cmp_val),
    .count_o(cnt_s), .tick_o(tick_s), .ovf_o(ovf_s), .match_o(match_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Applies the rules of one rising edge to the reference model.
  task automatic model_edge();
    bit do_step;
    int nx;
    bit hit;
    if (rst) begin
      m_pre = 0;
      m_tick = 0;
      for (int s = 0; s < 2; s++) begin
        m_cnt[s] = 0; m_ovf[s] = 0; m_match[s] = 0;
      end
    end else if (load) begin
      m_pre = 0;
      m_tick = 0;
      for (int s = 0; s < 2; s++) begin
        m_cnt[s] = load_val; m_ovf[s] = 0; m_match[s] = (load_val == cmp_val);
      end
    end else begin
      do_step = en && (m_pre >= prescale);
      if (en) m_pre = do_step ? 0 : m_pre + 1;
      m_tick = do_step;
      for (int s = 0; s < 2; s++) begin
        m_ovf[s] = 0;
        m_match[s] = 0;
        if (do_step) begin
          nx  = m_cnt[s] + (dir ? -1 : 1);
          hit = (nx < 0) || (nx > MAXV);
          if (hit) nx = (s == 1) ? m_cnt[s] : ((nx + MAXV + 1) % (MAXV + 1));
          m_cnt[s]   = nx;
          m_ovf[s]   = hit;
          m_match[s] = (nx == cmp_val);
        end
      end
    end
  endtask

  task automatic edge_check();
    @(posedge clk);
    #1;
    model_edge();
    check("cnt_w",   cnt_w,   m_cnt[0]);
    check("tick_w",  tick_w,  m_tick);
    check("ovf_w",   ovf_w,   m_ovf[0]);
    check("match_w", match_w, m_match[0]);
    check("cnt_s",   cnt_s,   m_cnt[1]);
    check("tick_s",  tick_s,  m_tick);
    check("ovf_s",   ovf_s,   m_ovf[1]);
    check("match_s", match_s, m_match[1]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) edge_check();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    edge_check();
    load = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = '0; cmp_val = 8'hAA; prescale = '0;
    m_pre = 0; m_tick = 0;
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_ovf[s] = 0; m_match[s] = 0;
    end
    run(2);
    check("reset_cnt", cnt_w, 0);
    rst = 1'b0;

    // Count every enabled cycle.
    en = 1'b1;
    run(3);
    check("up_by_one", cnt_w, 3);

    // Prescale by 3 with an enable gap in the middle.
    do_load(8'h00);
    prescale = 4'd2;
    run(4);
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(5);
    check("prescaled", cnt_w, 3);

    // Limits: wrap vs saturate going up, then down.
    prescale = '0;
    do_load(8'hFE);
    run(2);
    check("wrap_up",   cnt_w, 8'h00);
    check("wrap_ovf",  ovf_w, 1);
    check("sat_up",    cnt_s, 8'hFF);
    run(2);
    dir = 1'b1;
    do_load(8'h01);
    run(2);
    check("wrap_down", cnt_w, 8'hFF);
    check("sat_down",  cnt_s, 8'h00);
    check("sat_ovf",   ovf_s, 1);

    // Compare match on counting, on load, and no repeat while idle.
    dir = 1'b0; cmp_val = 8'd5;
    do_load(8'd0);
    run(6);
    en = 1'b0;
    do_load(8'd5);
    check("match_load", match_w, 1);
    run(3);
    check("match_idle", match_w, 0);

    // Load beats a coincident step; reset beats load.
    en = 1'b1;
    do_load(8'h40);
    check("load_no_tick", tick_w, 0);
    rst = 1'b1; load = 1'b1; load_val = 8'h77;
    edge_check();
    check("rst_over_load", cnt_w, 0);
    rst = 1'b0; load = 1'b0; prescale = 4'd3;
    run(6);

    // Randomised traffic biased toward limits and matches.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      rst  = (r < 2);
      load = (r >= 2 && r < 12);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0)
        prescale = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 15))
                                               : PW'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       load_val = 8'h00;
        1:       load_val = 8'hFF;
        default: load_val = W'($urandom_range(0, MAXV));
      endcase
      if ($urandom_range(0, 3) == 0)
        cmp_val = W'((m_cnt[0] + (dir ? -1 : 1) + MAXV + 1) % (MAXV + 1));
      edge_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
